// File: rtl/calc_pkg.sv
// Shared calculator definitions: button codes and the keypad scanner state type.
// The button classifier imports the same constants, so codes are defined once here.
package calc_pkg;

  localparam logic [4:0] BTN_ADD  = 5'd10;
  localparam logic [4:0] BTN_SUB  = 5'd11;
  localparam logic [4:0] BTN_MUL  = 5'd12;
  localparam logic [4:0] BTN_DIV  = 5'd13;
  localparam logic [4:0] BTN_EQ   = 5'd14;
  localparam logic [4:0] BTN_CLR  = 5'd15;
  localparam logic [4:0] BTN_NONE = 5'd31;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    RELEASE  = 2'd3
  } scanState_t;

endpackage

// File: rtl/keypad_decode.sv
// Combinational keypad decoder: (driven column index, active-low row pattern)
// -> 5-bit button code plus a valid flag. Only a pattern with exactly one row
// low is a key; all-high and multi-row patterns report BTN_NONE / not valid.
module keypad_decode
  import calc_pkg::*;
(
  input  logic [1:0] colIdx,
  input  logic [3:0] rowPat,
  output logic [4:0] code,
  output logic       valid
);

  logic [1:0] rowIdx;

  // Turn the single low row bit into a row index; everything else is not a key.
  always_comb begin
    valid  = 1'b1;
    rowIdx = 2'd0;
    case (rowPat)
      4'b1110: rowIdx = 2'd0;
      4'b1101: rowIdx = 2'd1;
      4'b1011: rowIdx = 2'd2;
      4'b0111: rowIdx = 2'd3;
      default: valid  = 1'b0;
    endcase
  end

  // Physical key map: rows 0-2 hold digits plus an operator, row 3 is C 0 = /.
  always_comb begin
    code = BTN_NONE;
    if (valid) begin
      case ({rowIdx, colIdx})
        4'd0:    code = 5'd1;
        4'd1:    code = 5'd2;
        4'd2:    code = 5'd3;
        4'd3:    code = BTN_ADD;
        4'd4:    code = 5'd4;
        4'd5:    code = 5'd5;
        4'd6:    code = 5'd6;
        4'd7:    code = BTN_SUB;
        4'd8:    code = 5'd7;
        4'd9:    code = 5'd8;
        4'd10:   code = 5'd9;
        4'd11:   code = BTN_MUL;
        4'd12:   code = BTN_CLR;
        4'd13:   code = 5'd0;
        4'd14:   code = BTN_EQ;
        4'd15:   code = BTN_DIV;
        default: code = BTN_NONE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner with debounce. Walks a one-hot active-low column
// drive, samples the synchronised rows once per tick, debounces press and
// release, and emits a one-cycle validPress with the accepted button code.
// Optional auto-repeat of held digit keys is enabled by KEYPAD_AUTOREPEAT_EN.
//
// validPress/button handshake: validPress is a single-cycle strobe with no
// ready; button is valid in that cycle and holds until the next strobe. The
// consumer must capture on the strobe; there is no back-pressure.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_CNT   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       validPress,
  output logic [4:0] button,
  output scanState_t dbgState
);

  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
  logic [REP_W-1:0] repCnt;
`else
  localparam int unusedRepeatCnt = REPEAT_CNT;
`endif

  scanState_t        state;
  logic [3:0]        rowSync;
  logic [3:0]        rows;
  logic [TICK_W-1:0] tickCnt;
  logic              tick;
  logic [1:0]        colIdx;
  logic [DEB_W-1:0]  debCnt;
  logic [3:0]        latchedRows;
  logic [4:0]        decCode;
  logic              decValid;

  assign tick     = (tickCnt == TICK_LAST);
  assign dbgState = state;

  keypad_decode uDecode (
    .colIdx (colIdx),
    .rowPat (rows),
    .code   (decCode),
    .valid  (decValid)
  );

  // Two-flop synchroniser for the asynchronous, pulled-up row inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rowSync <= 4'hF;
      rows    <= 4'hF;
    end else begin
      rowSync <= row_in;
      rows    <= rowSync;
    end
  end

  // Tick counter; columns only change on a tick, so wrapping here also
  // restarts the count on every column change.
  always_ff @(posedge clk) begin
    if (reset || tick) tickCnt <= '0;
    else               tickCnt <= tickCnt + 1'b1;
  end

  // Scan / debounce / press / release state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      colIdx      <= 2'd0;
      col_out     <= 4'b1110;
      debCnt      <= '0;
      latchedRows <= 4'hF;
      validPress  <= 1'b0;
      button      <= BTN_NONE;
`ifdef KEYPAD_AUTOREPEAT_EN
      repCnt      <= '0;
`endif
    end else begin
      validPress <= 1'b0;
      case (state)
        SCAN: begin
          if (tick) begin
            if (decValid) begin
              latchedRows <= rows;
              debCnt      <= DEB_W'(1);
              state       <= DEBOUNCE;
            end else begin
              colIdx  <= colIdx + 1'b1;
              col_out <= {col_out[2:0], col_out[3]};
            end
          end
        end
        DEBOUNCE: begin
          if (tick) begin
            if (rows == latchedRows) begin
              if (debCnt == DEB_LAST) begin
                state      <= PRESS;
                validPress <= 1'b1;
                button     <= decCode;
              end else begin
                debCnt <= debCnt + 1'b1;
              end
            end else begin
              state   <= SCAN;
              colIdx  <= colIdx + 1'b1;
              col_out <= {col_out[2:0], col_out[3]};
            end
          end
        end
        PRESS: begin
          state  <= RELEASE;
          debCnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          repCnt <= '0;
`endif
        end
        RELEASE: begin
          if (tick) begin
            if (rows == 4'hF) begin
              if (debCnt == DEB_LAST) begin
                state   <= SCAN;
                colIdx  <= colIdx + 1'b1;
                col_out <= {col_out[2:0], col_out[3]};
              end else begin
                debCnt <= debCnt + 1'b1;
              end
            end else begin
              debCnt <= '0;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            // Held digit keys re-strobe every REPEAT_CNT ticks; operators do not.
            if (rows == latchedRows) begin
              if (repCnt == REP_LAST) begin
                repCnt <= '0;
                if (button <= 5'd9) validPress <= 1'b1;
              end else begin
                repCnt <= repCnt + 1'b1;
              end
            end else begin
              repCnt <= '0;
            end
`endif
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3,
// REPEAT_CNT=5). A keypad matrix model pulls a row low while a pressed key's
// column is driven; expected button codes are queued when a key is pressed and
// checked by a monitor whenever validPress strobes.
module tb_keypad_scanner;
  import calc_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_CNT   = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       validPress;
  logic [4:0] button;
  scanState_t dbgState;

  logic [15:0] pressMask = '0;
  logic [4:0]  exp_q[$];
  int          keyMap[16];
  int          compared = 0;
  int          mismatched = 0;
  logic        prevValid = 1'b0;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_CNT   (REPEAT_CNT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row_in     (row_in),
    .col_out    (col_out),
    .validPress (validPress),
    .button     (button),
    .dbgState   (dbgState)
  );

  // clock
  always #5 clk = ~clk;

  // keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressMask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // scoreboard monitor: every strobe pops one expected code
  always @(negedge clk) begin
    logic [4:0] expCode;
    if (!reset) begin
      if (validPress) begin
        compared++;
        if (prevValid) begin
          mismatched++;
          $display("FAIL strobe_width: validPress=1 in consecutive cycles, required single cycle");
        end
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_strobe: button=%0d strobed, required no strobe", button);
        end else begin
          expCode = exp_q.pop_front();
          if (button !== expCode) begin
            mismatched++;
            $display("FAIL button_code: got %0d, required %0d", button, expCode);
          end
        end
      end
      prevValid = validPress;
    end else begin
      prevValid = 1'b0;
    end
  end

  task automatic wait_col_enter(input logic [3:0] pat, input int budget, input string name);
    logic [3:0] prev;
    bit hit;
    prev = col_out;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (col_out === pat && prev !== pat) hit = 1;
      prev = col_out;
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL %s: col_out=%b after %0d cycles, required entry into %b", name, col_out, budget, pat);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s: %0d strobes still pending after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [3:0] expCol;
    reset = 1'b1;
    pressMask = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (col_out !== 4'b1110) begin mismatched++; $display("FAIL reset_col: got %b, required 1110", col_out); end
    compared++;
    if (button !== 5'd31) begin mismatched++; $display("FAIL reset_button: got %0d, required 31", button); end
    compared++;
    if (validPress !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b, required 0", validPress); end
    compared++;
    if (dbgState !== SCAN) begin mismatched++; $display("FAIL reset_state: got %0d, required SCAN", dbgState); end
    reset = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) @(negedge clk);
      expCol = 4'b1111 ^ (4'b0001 << ((j / 4) % 4));
      compared++;
      if (col_out !== expCol) begin
        mismatched++;
        $display("FAIL col_walk[%0d]: got %b, required %b", j, col_out, expCol);
      end
    end
  endtask

  task automatic test_press_latency();
    int n;
    wait_col_enter(4'b1101, 40, "press_find_col1");
    pressMask[1*4+1] = 1'b1;
    exp_q.push_back(5'd5);
    n = 0;
    for (int i = 1; i <= 30 && n == 0; i++) begin
      @(negedge clk);
      if (validPress) n = i;
    end
    compared++;
    if (n != 12) begin mismatched++; $display("FAIL press_latency: strobe after %0d cycles, required 12", n); end
    repeat (40) @(negedge clk);
    compared++;
    if (col_out !== 4'b1101) begin mismatched++; $display("FAIL press_hold_col: got %b, required 1101", col_out); end
    // second key in the same column while the first is held, then first released
    pressMask[2*4+1] = 1'b1;
    repeat (8) @(negedge clk);
    pressMask[1*4+1] = 1'b0;
    repeat (30) @(negedge clk);
    compared++;
    if (dbgState !== RELEASE) begin mismatched++; $display("FAIL second_key_hold: state %0d, required RELEASE", dbgState); end
    pressMask[2*4+1] = 1'b0;
    wait_col_enter(4'b1011, 30, "press_release_advance");
    wait_drain(1, "press_drain");
  endtask

  task automatic test_bounce();
    wait_col_enter(4'b1110, 40, "bounce_find_col0");
    pressMask[0] = 1'b1;
    repeat (8) @(negedge clk);
    pressMask[0] = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (col_out !== 4'b1110) begin mismatched++; $display("FAIL bounce_hold_col: got %b, required 1110", col_out); end
    @(negedge clk);
    compared++;
    if (col_out !== 4'b1101) begin mismatched++; $display("FAIL bounce_resume: got %b, required 1101", col_out); end
    wait_col_enter(4'b1110, 40, "stable_find_col0");
    pressMask[0] = 1'b1;
    exp_q.push_back(5'd1);
    wait_drain(30, "stable_press");
    pressMask[0] = 1'b0;
    wait_col_enter(4'b1101, 30, "stable_release_advance");
  endtask

  task automatic test_invalid();
    wait_col_enter(4'b0111, 40, "invalid_find_col3");
    pressMask[0*4+3] = 1'b1;
    pressMask[2*4+3] = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (col_out !== 4'b0111) begin mismatched++; $display("FAIL invalid_col3: got %b, required 0111", col_out); end
    @(negedge clk);
    compared++;
    if (col_out !== 4'b1110) begin mismatched++; $display("FAIL invalid_advance: got %b, required 1110", col_out); end
    repeat (24) @(negedge clk);
    compared++;
    if (dbgState !== SCAN) begin mismatched++; $display("FAIL invalid_state: got %0d, required SCAN", dbgState); end
    pressMask = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_keymap();
    for (int k = 0; k < 16; k++) begin
      pressMask = '0;
      pressMask[k] = 1'b1;
      exp_q.push_back(keyMap[k][4:0]);
      wait_drain(60, "keymap_strobe");
      pressMask = '0;
      repeat (24) @(negedge clk);
      compared++;
      if (dbgState !== SCAN) begin mismatched++; $display("FAIL keymap_release[%0d]: state %0d, required SCAN", k, dbgState); end
    end
  endtask

  task automatic test_reset_mid_debounce();
    wait_col_enter(4'b1011, 40, "midreset_find_col2");
    pressMask[0*4+2] = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (col_out !== 4'b1110) begin mismatched++; $display("FAIL midreset_col: got %b, required 1110", col_out); end
    compared++;
    if (validPress !== 1'b0) begin mismatched++; $display("FAIL midreset_valid: got %b, required 0", validPress); end
    compared++;
    if (button !== 5'd31) begin mismatched++; $display("FAIL midreset_button: got %0d, required 31", button); end
    compared++;
    if (dbgState !== SCAN) begin mismatched++; $display("FAIL midreset_state: got %0d, required SCAN", dbgState); end
    pressMask = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int hits;
    int firstGap;
    int secondGap;
    bit seen;
    pressMask = '0;
    pressMask[2*4+0] = 1'b1;
    repeat (3) exp_q.push_back(5'd7);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (validPress) seen = 1;
    end
    hits = 0;
    firstGap = 0;
    secondGap = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (validPress) begin
        hits++;
        if (hits == 1) firstGap = i;
        if (hits == 2) secondGap = i;
      end
    end
    compared++;
    if (hits != 2 || firstGap != 20 || secondGap != 40) begin
      mismatched++;
      $display("FAIL repeat_timing: %0d repeats at +%0d/+%0d, required 2 at +20/+40", hits, firstGap, secondGap);
    end
    pressMask = '0;
    repeat (30) @(negedge clk);
    wait_drain(1, "repeat_digit_drain");
    pressMask[3*4+2] = 1'b1;
    exp_q.push_back(BTN_EQ);
    wait_drain(60, "repeat_eq_first");
    repeat (60) @(negedge clk);
    pressMask = '0;
    repeat (30) @(negedge clk);
  endtask
`endif

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    keyMap = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 15, 0, 14, 13};
    test_reset();
    test_press_latency();
    test_bounce();
    test_invalid();
    test_keymap();
    test_reset_mid_debounce();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    wait_drain(1, "final_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
